// File: rtl/dmem_ctrl.sv
// Data-memory controller: aligns core loads/stores, posts stores through a write
// buffer and serialises all traffic onto a single-outstanding req/ack word bus.
module dmem_ctrl #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic              mem_oe,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_we,
  output logic [31:0]       mem_rdata,
  output logic              mem_valid,
  output logic              mem_ready,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_DRAIN = 2'd1,
    RD_REQ   = 2'd2
  } state_t;

  state_t            state, state_n;
  wr_entry_t         wbuf [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, head_idx;
  logic [CNT_W-1:0]  count, count_left;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic [1:0]        rd_off, rd_off_n;

  logic [1:0]        off;
  logic [7:0]        be_wide;
  logic [31:0]       wdata_sh;
  logic              st_misalign;
  logic              wbuf_full;
  logic              accept, push, pop, bus_free;
  logic              start_rd, start_wr, rd_done;

  // Only registered state feeds mem_ready, so the core may build mem_oe from it.
  assign wbuf_full = (count == CNT_W'(WBUF_DEPTH));
  assign mem_ready = (state == IDLE) && !wbuf_full;

  // Lane positioning of the incoming store and its alignment check.
  always_comb begin
    off         = mem_addr[1:0];
    be_wide     = {4'b0000, mem_we} << off;
    wdata_sh    = mem_wdata << {off, 3'b000};
    st_misalign = ((mem_we == 4'b0011) && off[0])
               || ((mem_we == 4'b1111) && (off != 2'b00))
               || (be_wide[7:4] != 4'b0000);
  end

  // Next-state logic; a bus slot is free when idle or completing this cycle.
  always_comb begin
    state_n    = state;
    rd_addr_n  = rd_addr;
    rd_off_n   = rd_off;
    accept     = mem_ready && mem_oe;
    push       = 1'b0;
    start_rd   = 1'b0;
    rd_done    = 1'b0;
    pop        = bus_req && bus_we && bus_ack;
    bus_free   = !bus_req || bus_ack;
    count_left = count - CNT_W'(pop);
    head_idx   = rd_ptr + PTR_W'(pop);

    case (state)
      IDLE: begin
        if (accept) begin
          if (mem_we == 4'b0000) begin
            rd_addr_n = mem_addr[ADDR_W+1:2];
            rd_off_n  = off;
            if (bus_free && (count_left == '0)) begin
              start_rd = 1'b1;
              state_n  = RD_REQ;
            end else begin
              state_n  = RD_DRAIN;
            end
          end else if (!st_misalign) begin
            push = 1'b1;
          end
        end
      end
      RD_DRAIN: begin
        // Buffered stores retire before the read so the load sees them.
        if (bus_free && (count_left == '0)) begin
          start_rd = 1'b1;
          state_n  = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bus_ack) begin
          rd_done = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    start_wr = bus_free && (count_left != '0) && !start_rd && (state != RD_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      rd_off  <= 2'b00;
    end else begin
      state   <= state_n;
      rd_addr <= rd_addr_n;
      rd_off  <= rd_off_n;
    end
  end

  // Write-buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_left + CNT_W'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wbuf[wr_ptr] <= '{addr: mem_addr[ADDR_W+1:2], be: be_wide[3:0], data: wdata_sh};
    end
  end

  // Bus request registers only change when a slot opens, so they stay stable until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
    end else if (start_rd) begin
      bus_req   <= 1'b1;
      bus_we    <= 1'b0;
      bus_addr  <= rd_addr_n;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
    end else if (start_wr) begin
      bus_req   <= 1'b1;
      bus_we    <= 1'b1;
      bus_addr  <= wbuf[head_idx].addr;
      bus_be    <= wbuf[head_idx].be;
      bus_wdata <= wbuf[head_idx].data;
    end else if (bus_ack) begin
      bus_req   <= 1'b0;
    end
  end

  // Core-side responses; mem_rdata holds until the next load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_rdata <= '0;
      misalign  <= 1'b0;
    end else begin
      mem_valid <= rd_done;
      if (rd_done) mem_rdata <= bus_rdata >> {rd_off, 3'b000};
      misalign  <= accept && (mem_we != 4'b0000) && st_misalign;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-level memory model, random bus responder,
// directed corner cases followed by a randomized load/store mix.
module tb_dmem_ctrl;

  localparam int unsigned ADDR_W     = 30;
  localparam int unsigned WBUF_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       mem_addr;
  logic              mem_oe;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_we;
  logic [31:0]       mem_rdata;
  logic              mem_valid;
  logic              mem_ready;
  logic              misalign;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W), .WBUF_DEPTH(WBUF_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          fixed_delay = -1;
  int          credits = -1;
  wr_exp_t     exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [29:0] exp_rdaddr_q[$];
  int          exp_mis_q[$];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [29:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a);
    logic [31:0] e;
    int          o;
    e = '0;
    o = int'(a[1:0]);
    for (int j = 0; j < 4 - o; j++) e[8*j +: 8] = ref_byte(a + 32'(j));
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One core access; returns load latency in cycles (accept edge to mem_valid).
  task automatic access(input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wdata, output int lat);
    int      t;
    logic    ready_seen;
    logic    mis;
    wr_exp_t w;
    lat = 0;
    t = 0;
    while (!mem_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!mem_ready) chk("ready_timeout", 64'(mem_ready), 64'd1);
    mem_addr  = addr;
    mem_we    = we;
    mem_wdata = wdata;
    mem_oe    = 1'b1;
    if (we == 4'b0000) begin
      exp_rd_q.push_back(ref_load(addr));
      exp_rdaddr_q.push_back(addr[31:2]);
    end else begin
      mis = ((we == 4'b0011) && addr[0]) || ((we == 4'b1111) && (addr[1:0] != 2'b00));
      if (mis) begin
        exp_mis_q.push_back(cyc + 1);
      end else begin
        for (int j = 0; j < 4; j++)
          if (we[j]) ref_mem[addr + 32'(j)] = wdata[8*j +: 8];
        w.addr = addr[31:2];
        w.be   = we << addr[1:0];
        w.data = wdata << (8 * int'(addr[1:0]));
        exp_wr_q.push_back(w);
      end
    end
    @(posedge clk); #1;
    mem_oe = 1'b0;
    mem_we = 4'b0000;
    if (we == 4'b0000) begin
      ready_seen = 1'b0;
      while (lat < 200) begin
        @(negedge clk);
        lat++;
        if (mem_valid) break;
        if (mem_ready) ready_seen = 1'b1;
      end
      chk("load_complete", 64'(mem_valid), 64'd1);
      chk("ready_low_during_load", 64'(ready_seen), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every load response and misalign pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid) begin
        if (exp_rd_q.size() == 0) chk("unexpected_mem_valid", 64'd1, 64'd0);
        else chk("load_data", 64'(mem_rdata), 64'(exp_rd_q.pop_front()));
      end
      if (misalign) begin
        if (exp_mis_q.size() == 0) chk("unexpected_misalign", 64'd1, 64'd0);
        else chk("misalign_cycle", 64'(cyc), 64'(exp_mis_q.pop_front()));
      end
    end
  end

  // Bus responder: backing memory, programmable ack delay, ordering and stability checks.
  initial begin : responder
    logic        in_txn;
    logic [66:0] cap;
    int          wait_cnt;
    int          delay;
    logic        stable;
    logic [31:0] word;
    wr_exp_t     w;
    in_txn = 1'b0;
    cap = '0;
    wait_cnt = 0;
    delay = 0;
    stable = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (bus_req && !rst) begin
        if (!in_txn) begin
          in_txn   = 1'b1;
          cap      = {bus_we, bus_addr, bus_be, bus_wdata};
          wait_cnt = 0;
          stable   = 1'b1;
          delay    = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
          if (!bus_we) begin
            chk("raw_order", 64'(exp_wr_q.size()), 64'd0);
            if (exp_rdaddr_q.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
            else chk("read_addr", 64'(bus_addr), 64'(exp_rdaddr_q.pop_front()));
          end
        end else if ({bus_we, bus_addr, bus_be, bus_wdata} !== cap) begin
          stable = 1'b0;
        end
        if (wait_cnt >= delay && credits != 0) begin
          if (credits > 0) credits--;
          bus_ack = 1'b1;
          word = bus_mem.exists(bus_addr) ? bus_mem[bus_addr] : 32'h0;
          if (bus_we) begin
            for (int j = 0; j < 4; j++)
              if (bus_be[j]) word[8*j +: 8] = bus_wdata[8*j +: 8];
            bus_mem[bus_addr] = word;
            if (exp_wr_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
            else begin
              w = exp_wr_q.pop_front();
              chk("write_addr", 64'(bus_addr), 64'(w.addr));
              chk("write_be_data", 64'({bus_be, bus_wdata}), 64'({w.be, w.data}));
            end
          end else begin
            bus_rdata = word;
          end
          chk("bus_stable", 64'(stable), 64'd1);
          in_txn = 1'b0;
        end else begin
          wait_cnt++;
        end
      end else begin
        in_txn = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int   lat;
    int   t;
    logic saw;
    logic [31:0] a;
    logic [3:0]  we;
    rst = 1'b1;
    mem_addr = '0;
    mem_oe = 1'b0;
    mem_wdata = '0;
    mem_we = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", 64'({mem_ready, bus_req, mem_valid, misalign, mem_rdata}), 64'({4'b1000, 32'h0}));

    // SB 0xAB @0x103 -> lane 3 of word 0x40
    access(32'h103, 4'b0001, 32'h000000AB, lat);
    idle(8);
    chk("sb_bus_word", 64'(bus_mem.exists(30'h40) ? bus_mem[30'h40] : 32'h0), 64'h00000000_AB000000);

    // LW @0x100 with a 3-cycle ack delay on an empty buffer
    access(32'h100, 4'b1111, 32'h11223344, lat);
    idle(8);
    fixed_delay = 3;
    access(32'h100, 4'b0000, 32'h0, lat);
    chk("lw_latency", 64'(lat), 64'd5);
    fixed_delay = 0;
    access(32'h102, 4'b0000, 32'h0, lat);
    chk("lbu_latency", 64'(lat), 64'd2);
    chk("lbu_data_const", 64'(mem_rdata), 64'h1122);
    fixed_delay = -1;

    // Four stores with acks withheld fill the buffer
    credits = 0;
    for (int i = 0; i < 4; i++) access(32'h140 + 32'(4 * i), 4'b1111, 32'hA0000000 + 32'(i), lat);
    chk("ready_low_when_full", 64'(mem_ready), 64'd0);
    credits = 1;
    t = 0;
    while (!bus_ack && t < 50) begin @(negedge clk); t++; end
    chk("one_ack_seen", 64'(bus_ack), 64'd1);
    @(posedge clk); #1;
    chk("ready_after_pop", 64'(mem_ready), 64'd1);
    credits = -1;
    idle(20);

    // Store then load to the same word with slow acks
    fixed_delay = 4;
    access(32'h200, 4'b1111, 32'hDEADBEEF, lat);
    access(32'h200, 4'b0000, 32'h0, lat);
    fixed_delay = -1;
    idle(10);

    // Misaligned halfword store is dropped
    access(32'h101, 4'b0011, 32'h00005555, lat);
    saw = 1'b0;
    repeat (6) begin @(negedge clk); if (bus_req) saw = 1'b1; end
    chk("no_bus_after_misalign", 64'(saw), 64'd0);
    @(posedge clk); #1;
    access(32'h102, 4'b0000, 32'h0, lat);

    // Reset while the read request is outstanding
    idle(5);
    credits = 0;
    mem_addr = 32'h100;
    mem_we = 4'b0000;
    mem_oe = 1'b1;
    exp_rd_q.push_back(ref_load(32'h100));
    exp_rdaddr_q.push_back(30'h40);
    @(posedge clk); #1;
    mem_oe = 1'b0;
    t = 0;
    while (!(bus_req && !bus_we) && t < 50) begin @(negedge clk); t++; end
    chk("read_req_before_reset", 64'({bus_req, bus_we}), 64'b10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (exp_rd_q.size() > 0) void'(exp_rd_q.pop_front());
    chk("reset_mid_load", 64'({bus_req, mem_ready, mem_valid}), 64'b010);
    credits = -1;
    idle(10);

    // Randomized mix over a small window so stores and loads collide
    for (int i = 0; i < 250; i++) begin
      a = 32'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: we = 4'b0000;
        4, 5, 6:    we = 4'b0001;
        7, 8:       we = 4'b0011;
        default:    we = 4'b1111;
      endcase
      access(a, we, $urandom, lat);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(30);

    chk("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    chk("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    chk("misalign_queue_drained", 64'(exp_mis_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
